// File: rtl/complex_multiply_pkg.sv
// Shared constants and {im, re} pack/unpack helpers for the complex multiply stream.
// The helpers work on a fixed 64-bit component / 128-bit bus and take the real
// component width as an argument, so callers cast to and from their own widths.
// Components up to 64 bits are supported, which covers WIDTH up to 32.
package complex_multiply_pkg;

  localparam int unsigned LATENCY    = 4;
  localparam int unsigned CPLX_MAX_W = 64;
  localparam int unsigned CPLX_BUS_W = 2 * CPLX_MAX_W;

  // Sign-extended real part of a {im, re} word with w-bit components.
  function automatic logic signed [CPLX_MAX_W-1:0] cplx_re(input logic [CPLX_BUS_W-1:0] c,
                                                           input int unsigned w);
    logic signed [CPLX_MAX_W-1:0] r;
    r = c[CPLX_MAX_W-1:0];
    r = r <<< (CPLX_MAX_W - w);
    return r >>> (CPLX_MAX_W - w);
  endfunction

  // Sign-extended imaginary part of a {im, re} word with w-bit components.
  function automatic logic signed [CPLX_MAX_W-1:0] cplx_im(input logic [CPLX_BUS_W-1:0] c,
                                                           input int unsigned w);
    logic signed [CPLX_MAX_W-1:0] r;
    r = CPLX_MAX_W'(c >> w);
    r = r <<< (CPLX_MAX_W - w);
    return r >>> (CPLX_MAX_W - w);
  endfunction

  // Packs the low w bits of re and im into {im, re}.
  function automatic logic [CPLX_BUS_W-1:0] cplx_pack(input logic [CPLX_MAX_W-1:0] re,
                                                      input logic [CPLX_MAX_W-1:0] im,
                                                      input int unsigned w);
    logic [CPLX_BUS_W-1:0] mask;
    mask = {CPLX_BUS_W{1'b1}} >> (CPLX_BUS_W - w);
    return (CPLX_BUS_W'(re) & mask) | ((CPLX_BUS_W'(im) & mask) << w);
  endfunction

endpackage

// File: rtl/complex_multiply_stage.sv
// One valid/ready pipeline register.
// Ports: clk, reset_n (sync, active low), in_valid/in_ready_c/in_data upstream,
//        out_valid/out_ready/out_data downstream.
// The stage loads whenever it is empty or its current contents leave on the same
// edge, so bubbles collapse. Only the valid bit is reset.
module complex_multiply_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready_c = !out_valid || out_ready;

  // Valid bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
    end else if (in_ready_c) begin
      out_valid <= in_valid;
    end
  end

  // Payload, unreset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready_c) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/complex_multiply_stream.sv
// Streaming complex multiplier: m = (a * b') >>> SHIFT, b' = conj(b) when s_conj.
// a = s_data[1], b = s_data[0], each packed {im, re} with WIDTH-bit components.
// Ports: clk, reset_n (sync, active low); s_valid/s_ready/s_data/s_conj/s_user in;
//        m_valid/m_ready/m_data/m_user out, m_data = {im, re} at 2*WIDTH bits each.
// Pipeline: input register -> four products -> add/sub -> shift (4 cycles).
// Macro COMPLEX_MULTIPLY_STREAM_ROUND_EN: add 2**(SHIFT-1) before the shift
// (round half up); otherwise the shift floors. SHIFT = 0 is exact either way.
module complex_multiply_stream
  import complex_multiply_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned SHIFT      = 1,
  parameter int unsigned USER_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [1:0][2*WIDTH-1:0]   s_data,
  input  logic                      s_conj,
  input  logic [USER_WIDTH-1:0]     s_user,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [4*WIDTH-1:0]        m_data,
  output logic [USER_WIDTH-1:0]     m_user
);

  localparam int unsigned PW = 2 * WIDTH;      // product / result component
  localparam int unsigned SW = 2 * WIDTH + 1;  // sum component
  localparam int unsigned RW = 2 * WIDTH + 2;  // sum plus rounding headroom
  localparam int unsigned DW = 4 * WIDTH;
  localparam int unsigned UW = USER_WIDTH;
  localparam int unsigned P1 = 1 + UW + DW;
  localparam int unsigned P2 = UW + 4 * PW;
  localparam int unsigned P3 = UW + 2 * SW;
  localparam int unsigned P4 = UW + DW;

`ifdef COMPLEX_MULTIPLY_STREAM_ROUND_EN
  localparam logic signed [RW-1:0] RND_ADD = (SHIFT == 0) ? '0 : (RW'(1) << (SHIFT - 1));
`else
  localparam logic signed [RW-1:0] RND_ADD = '0;
`endif

  logic          v1, v2, v3, v4;
  logic          rdy1_c, rdy2_c, rdy3_c, rdy4_c;
  logic [P1-1:0] d1;
  logic [P2-1:0] d2;
  logic [P3-1:0] d3;
  logic [P4-1:0] d4;
  logic [P2-1:0] d2_in_c;
  logic [P3-1:0] d3_in_c;
  logic [P4-1:0] d4_in_c;

  assign s_ready = reset_n && rdy1_c;
  assign m_valid = reset_n && v4;
  assign m_data  = d4[DW-1:0];
  assign m_user  = d4[DW +: UW];

  // Stage 1: operand register.
  complex_multiply_stage #(.W(P1)) u_s1 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(s_valid), .in_ready_c(rdy1_c), .in_data({s_conj, s_user, s_data}),
    .out_valid(v1), .out_ready(rdy2_c), .out_data(d1)
  );

  // Four products; conjugation negates the two terms that use b.im.
  logic                  s1_conj;
  logic [UW-1:0]         s1_user;
  logic signed [WIDTH-1:0] a_re_c, a_im_c, b_re_c, b_im_c;
  logic signed [PW-1:0]  p_rr_c, p_ii_c, p_ri_c, p_ir_c;

  assign s1_conj = d1[P1-1];
  assign s1_user = d1[DW +: UW];
  assign a_re_c  = WIDTH'(cplx_re(CPLX_BUS_W'(d1[PW +: PW]), WIDTH));
  assign a_im_c  = WIDTH'(cplx_im(CPLX_BUS_W'(d1[PW +: PW]), WIDTH));
  assign b_re_c  = WIDTH'(cplx_re(CPLX_BUS_W'(d1[0 +: PW]), WIDTH));
  assign b_im_c  = WIDTH'(cplx_im(CPLX_BUS_W'(d1[0 +: PW]), WIDTH));

  always_comb begin
    p_rr_c = PW'(a_re_c) * PW'(b_re_c);
    p_ir_c = PW'(a_im_c) * PW'(b_re_c);
    p_ii_c = PW'(a_im_c) * PW'(b_im_c);
    p_ri_c = PW'(a_re_c) * PW'(b_im_c);
    if (s1_conj) begin
      p_ii_c = -p_ii_c;
      p_ri_c = -p_ri_c;
    end
  end

  assign d2_in_c = {s1_user, p_rr_c, p_ii_c, p_ri_c, p_ir_c};

  complex_multiply_stage #(.W(P2)) u_s2 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v1), .in_ready_c(rdy2_c), .in_data(d2_in_c),
    .out_valid(v2), .out_ready(rdy3_c), .out_data(d2)
  );

  // Add/subtract at 2*WIDTH+1 bits.
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
  logic signed [SW-1:0] re_sum_c, im_sum_c;

  assign s2_ir    = d2[0 +: PW];
  assign s2_ri    = d2[PW +: PW];
  assign s2_ii    = d2[2*PW +: PW];
  assign s2_rr    = d2[3*PW +: PW];
  assign re_sum_c = SW'(s2_rr) - SW'(s2_ii);
  assign im_sum_c = SW'(s2_ri) + SW'(s2_ir);
  assign d3_in_c  = {d2[4*PW +: UW], re_sum_c, im_sum_c};

  complex_multiply_stage #(.W(P3)) u_s3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v2), .in_ready_c(rdy3_c), .in_data(d3_in_c),
    .out_valid(v3), .out_ready(rdy4_c), .out_data(d3)
  );

  // Optional rounding bias, arithmetic shift, wrap to 2*WIDTH and pack {im, re}.
  logic signed [SW-1:0] s3_re, s3_im;
  logic signed [RW-1:0] re_sh_c, im_sh_c;

  assign s3_im   = d3[0 +: SW];
  assign s3_re   = d3[SW +: SW];
  assign re_sh_c = (RW'(s3_re) + RND_ADD) >>> SHIFT;
  assign im_sh_c = (RW'(s3_im) + RND_ADD) >>> SHIFT;
  assign d4_in_c = {d3[2*SW +: UW],
                    DW'(cplx_pack(CPLX_MAX_W'(re_sh_c), CPLX_MAX_W'(im_sh_c), PW))};

  complex_multiply_stage #(.W(P4)) u_s4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v3), .in_ready_c(rdy4_c), .in_data(d4_in_c),
    .out_valid(v4), .out_ready(m_ready), .out_data(d4)
  );

endmodule

// File: tb/tb_complex_multiply_stream.sv
// Self-checking bench for complex_multiply_stream (WIDTH=16, SHIFT=1, USER_WIDTH=8).
// Honors COMPLEX_MULTIPLY_STREAM_ROUND_EN for expected values.
module tb_complex_multiply_stream;

  localparam int unsigned SHIFT = 1;
`ifdef COMPLEX_MULTIPLY_STREAM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [1:0][31:0]  s_data = '0;
  logic              s_conj = 1'b0;
  logic [7:0]        s_user = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [63:0]       m_data;
  logic [7:0]        m_user;

  complex_multiply_stream #(.WIDTH(16), .SHIFT(SHIFT), .USER_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_conj(s_conj), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [7:0]  user;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] a_re, a_im, b_re, b_im;
    logic        conj;
    int          re_fl, im_fl, re_rn, im_rn;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          out_count = 0;
  int          last_out = 0;
  int          last_acc = 0;
  int          sready_low = 0;
  bit          check_lat = 1'b0;
  bit          rand_ready = 1'b0;
  logic [31:0] last_re, last_im;
  exp_t        q[$];
  exp_t        mon_e;
  bit          hold_pending = 1'b0;
  logic [63:0] held_data;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: full-precision complex product, optional bias, arithmetic shift, wrap to 32 bits.
  function automatic exp_t model(input logic [1:0][31:0] d, input logic conj, input logic [7:0] user);
    longint ar, ai, br, bi, re, im;
    exp_t e;
    ar = longint'($signed(d[1][15:0]));
    ai = longint'($signed(d[1][31:16]));
    br = longint'($signed(d[0][15:0]));
    bi = longint'($signed(d[0][31:16]));
    if (conj) bi = -bi;
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    if (RND && SHIFT > 0) begin
      re = re + (longint'(1) << (SHIFT - 1));
      im = im + (longint'(1) << (SHIFT - 1));
    end
    re = re >>> SHIFT;
    im = im >>> SHIFT;
    e.re = 32'(re);
    e.im = 32'(im);
    e.user = user;
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshakes seen at negedge complete on the following posedge (cyc+1).
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && m_valid)
        check("hold_stable", longint'(m_data), longint'(held_data));
      hold_pending = m_valid && !m_ready;
      held_data = m_data;
      if (s_valid && s_ready) begin
        mon_e = model(s_data, s_conj, s_user);
        mon_e.acc = cyc + 1;
        q.push_back(mon_e);
      end
      if (m_valid && m_ready) begin
        out_count++;
        last_out = cyc + 1;
        last_re = m_data[31:0];
        last_im = m_data[63:32];
        check("pending_beat", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          mon_e = q.pop_front();
          check("out_re", longint'($signed(m_data[31:0])), longint'($signed(mon_e.re)));
          check("out_im", longint'($signed(m_data[63:32])), longint'($signed(mon_e.im)));
          check("out_user", longint'(m_user), longint'(mon_e.user));
          if (check_lat) check("latency", longint'(cyc + 1 - mon_e.acc), 4);
        end
      end
    end
  end

  // Random back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one beat and returns just after the edge that accepts it; s_valid stays high.
  task automatic send(input logic [1:0][31:0] d, input logic conj, input logic [7:0] user);
    int guard;
    s_valid = 1'b1;
    s_data = d;
    s_conj = conj;
    s_user = user;
    guard = 0;
    @(negedge clk);
    while (!s_ready && guard < 2000) begin
      sready_low++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) check("s_ready_wait", guard, 0);
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_outputs(input int target);
    int guard;
    guard = 0;
    while (out_count < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (out_count < target) check("output_wait", out_count, target);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0][31:0] rand_data();
    logic [1:0][31:0] d;
    d[0] = $urandom;
    d[1] = $urandom;
    return d;
  endfunction

  vec_t vt[7];

  initial begin
    logic [1:0][31:0] d;
    int base, first_acc;

    vt[0] = '{16'd0,    16'd100,  16'd100,  16'd0,    1'b0, 0, 5000, 0, 5000};
    vt[1] = '{16'd3,    16'd4,    16'd1,    16'd2,    1'b1, 5, -1, 6, -1};
    vt[2] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 0, 1073741824, 0, 1073741824};
    vt[3] = '{16'd1,    16'd1,    16'd1,    16'd1,    1'b0, 0, 1, 0, 1};
    vt[4] = '{16'hFFFF, 16'd0,    16'd1,    16'd0,    1'b0, -1, 0, 0, 0};
    vt[5] = '{16'd7,    16'hFFFD, 16'hFFFE, 16'd5,    1'b0, 0, 20, 1, 21};
    vt[6] = '{16'd2,    16'd0,    16'd0,    16'h8000, 1'b1, 0, 32768, 0, 32768};

    // Reset behaviour.
    repeat (2) @(negedge clk);
    check("m_valid_in_reset", longint'(m_valid), 0);
    check("s_ready_in_reset", longint'(s_ready), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_reset", longint'(s_ready), 1);
    check("m_valid_after_reset", longint'(m_valid), 0);
    @(posedge clk);
    #1;

    // Directed vectors, one beat at a time.
    m_ready = 1'b1;
    check_lat = 1'b1;
    for (int i = 0; i < 7; i++) begin
      base = out_count;
      d[1] = {vt[i].a_im, vt[i].a_re};
      d[0] = {vt[i].b_im, vt[i].b_re};
      send(d, vt[i].conj, 8'(i));
      s_valid = 1'b0;
      wait_outputs(base + 1);
      check($sformatf("vec%0d_re", i), longint'($signed(last_re)),
            longint'(RND ? vt[i].re_rn : vt[i].re_fl));
      check($sformatf("vec%0d_im", i), longint'($signed(last_im)),
            longint'(RND ? vt[i].im_rn : vt[i].im_fl));
    end

    // 256-beat ramp tag, random operands, random bubbles and back-pressure.
    check_lat = 1'b0;
    rand_ready = 1'b1;
    base = out_count;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(rand_data(), 1'($urandom_range(0, 1)), 8'(i));
    end
    s_valid = 1'b0;
    wait_outputs(base + 256);
    check("ramp_count", out_count - base, 256);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three beats in flight.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_data(), 1'b0, 8'(100 + i));
    s_valid = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("m_valid_after_midreset", longint'(m_valid), 0);
    m_ready = 1'b1;
    base = out_count;
    repeat (10) @(negedge clk);
    check("no_stale_output", out_count - base, 0);
    @(posedge clk);
    #1;

    // 256 back-to-back beats with m_ready held high.
    check_lat = 1'b1;
    sready_low = 0;
    base = out_count;
    first_acc = 0;
    for (int i = 0; i < 256; i++) begin
      send(rand_data(), 1'($urandom_range(0, 1)), 8'(i));
      if (i == 0) first_acc = last_acc;
    end
    s_valid = 1'b0;
    wait_outputs(base + 256);
    check("b2b_count", out_count - base, 256);
    check("b2b_span", last_out - first_acc, 259);
    check("b2b_s_ready_low", sready_low, 0);
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_multiply_stream.md
COMPLEX_MULTIPLY_STREAM -- requirements
Module: complex_multiply_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed bits per real/imag input component.
REQ-002 SHALL have parameter SHIFT, default 1, meaning arithmetic right shift applied to each result component; legal range 0..WIDTH.
REQ-003 SHALL have parameter USER_WIDTH, default 8, meaning width of the per-beat sideband tag.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports s_valid input 1 and s_ready output 1, the input handshake.
REQ-007 SHALL have port s_data, input, [1:0][2*WIDTH-1:0], two complex operands, each packed {im, re}.
REQ-008 SHALL have port s_conj, input, 1, which conjugates operand s_data[0] for that beat when high.
REQ-009 SHALL have port s_user, input, USER_WIDTH, a tag carried unchanged alongside the beat.
REQ-010 SHALL have ports m_valid output 1 and m_ready input 1, the output handshake.
REQ-011 SHALL have port m_data, output, 4*WIDTH, the product packed {im, re} with 2*WIDTH bits per component.
REQ-012 SHALL have port m_user, output, USER_WIDTH, the tag of the beat presented on m_data.

Function
REQ-013 SHALL transfer a beat on any edge where valid and ready are both high, on either port.
REQ-014 SHALL compute, for a = s_data[1] and b = s_data[0] (b conjugated if s_conj), re = (a.re*b.re - a.im*b.im) >>> SHIFT and im = (a.re*b.im + a.im*b.re) >>> SHIFT.
REQ-015 SHALL form products at 2*WIDTH signed bits, sums at 2*WIDTH+1 bits, then shift and truncate to 2*WIDTH bits; truncation wraps silently.
REQ-016 SHALL use a 4-stage pipeline: input register, four products, add/subtract, shift.
REQ-017 SHALL present a beat accepted on edge N at m_valid on edge N+4 when nothing stalls downstream.
REQ-018 SHALL sustain one beat per cycle with s_valid and m_ready held high.
REQ-019 SHALL advance each stage independently: a stage loads when it is empty or its contents move on the same edge, so bubbles collapse.
REQ-020 SHALL drive s_ready high when stage 1 is empty or stage 1 advances on that edge.
REQ-021 SHALL hold m_data and m_user stable while m_valid is high and m_ready is low.
REQ-022 SHALL emit beats in acceptance order with no loss or duplication under any m_ready pattern.
REQ-023 SHALL accept a new beat and emit a completed beat on the same edge when the pipe is full and m_ready is high.

Reset
REQ-024 SHALL clear every stage valid bit while reset_n is low; m_valid = 0 and s_ready = 0 during reset.
REQ-025 SHALL drive s_ready = 1 on the first cycle after reset_n rises.
REQ-026 SHALL discard all beats in flight when reset_n is asserted mid-stream; no stale beat appears after release.
REQ-027 SHALL leave the data and user registers unreset; only the valid bits are reset.

Configuration
REQ-028 SHALL support the macro COMPLEX_MULTIPLY_STREAM_ROUND_EN: when defined, 2**(SHIFT-1) is added before the shift (round half up); when undefined, the shift floors. Either way, SHIFT = 0 is an exact pass-through.

Structure
REQ-029 SHALL place the constant LATENCY = 4 and the {im, re} pack/unpack functions in package complex_multiply_pkg.
REQ-030 SHALL implement each valid/ready pipeline stage as sub-module complex_multiply_stage, parametrised by payload width.

Verification (WIDTH=16, SHIFT=1)
REQ-031 SHALL check a = 100j, b = 100, conj 0 -> m_data im = 5000, re = 0 at 4 cycles latency.
REQ-032 SHALL check a = 3+4j, b = 1+2j, conj 1 -> re = 5, im = -1 without the macro; re = 6, im = -1 with it.
REQ-033 SHALL check a = b = -32768-32768j -> re = 0, im = 1073741824.
REQ-034 SHALL check a 256-beat ramp with s_user = i and random 50% m_ready -> every output is in order and m_user = i.
REQ-035 SHALL check reset_n driven low for 1 cycle with 3 beats in flight -> m_valid = 0 next cycle and no output until new input.
REQ-036 SHALL check 256 back-to-back beats with m_ready = 1 -> the last output occurs 259 cycles after the first acceptance, with s_ready never low.
